// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular FIFO of free physical register tags with revert and head checkpoints
module phys_reg_free_list #(
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_ARCH_REGS   = 32,
    parameter int NUM_CHECKPOINTS = 4,
    localparam int PR_W   = $clog2(NUM_PHYS_REGS),
    localparam int DEPTH  = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int SLOT_W = $clog2(DEPTH),
    localparam int PTR_W  = SLOT_W + 1,
    localparam int CK_W   = $clog2(NUM_CHECKPOINTS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dequeue_valid,
    output logic              dequeue_ready,
    output logic [PR_W-1:0]   dequeue_phys_reg_tag,
    input  logic              enqueue_valid,
    input  logic [PR_W-1:0]   enqueue_phys_reg_tag,
    input  logic              revert_valid,
    input  logic [PR_W-1:0]   revert_phys_reg_tag,
    input  logic              save_checkpoint_valid,
    input  logic [CK_W-1:0]   save_checkpoint_column,
    input  logic              restore_checkpoint_valid,
    input  logic [CK_W-1:0]   restore_checkpoint_column,
    output logic [PTR_W-1:0]  free_count,
    output logic              error
);
    logic [PR_W-1:0]  entry_q [DEPTH];
    logic [PR_W-1:0]  entry_d [DEPTH];
    logic [PTR_W-1:0] snap_q  [NUM_CHECKPOINTS];
    logic [PTR_W-1:0] snap_d  [NUM_CHECKPOINTS];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count, head_m1;
    logic             error_q, error_d, full, deq_fire, rev_fire, enq_fire;

    // Next-state: head priority restore > revert > dequeue, tail moved only by enqueue
    always_comb begin
        count    = tail_q - head_q;
        full     = count == PTR_W'(DEPTH);
        head_m1  = head_q - PTR_W'(1);
        deq_fire = dequeue_valid && count != '0 && !revert_valid && !restore_checkpoint_valid;
        rev_fire = revert_valid && !restore_checkpoint_valid && !full;
        enq_fire = enqueue_valid && !full;
        error_d  = full && (enqueue_valid || (revert_valid && !restore_checkpoint_valid));
        head_d   = restore_checkpoint_valid ? snap_q[restore_checkpoint_column] :
                   rev_fire ? head_m1 :
                   deq_fire ? head_q + PTR_W'(1) : head_q;
        tail_d   = enq_fire ? tail_q + PTR_W'(1) : tail_q;
        entry_d  = entry_q;
        if (rev_fire) entry_d[head_m1[SLOT_W-1:0]] = revert_phys_reg_tag;
        if (enq_fire) entry_d[tail_q[SLOT_W-1:0]] = enqueue_phys_reg_tag;
        snap_d   = snap_q;
        if (save_checkpoint_valid && !restore_checkpoint_valid) snap_d[save_checkpoint_column] = head_d;
    end

    // State registers; reset fills the list with the tags above the architectural range
    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= PTR_W'(DEPTH);
            error_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= PR_W'(NUM_ARCH_REGS + i);
            for (int i = 0; i < NUM_CHECKPOINTS; i++) snap_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            error_q <= error_d;
            entry_q <= entry_d;
            snap_q  <= snap_d;
        end
    end

    assign free_count           = tail_q - head_q;
    assign dequeue_ready        = free_count != '0;
    assign dequeue_phys_reg_tag = entry_q[head_q[SLOT_W-1:0]];
    assign error                = error_q;
endmodule
